// File: rtl/mac_arbiter_if.sv
// Bus between the filter engines and the shared multiply-dequantize unit.
// The engines drive the master side and mac_arbiter takes the slave side.
interface mac_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0]                 lock;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op_b;
  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_REQ-1:0]                 res_valid;
  logic [DATA_WIDTH-1:0]              res_data;
  logic                               busy;

  modport master (
    output req, lock, op_a, op_b,
    input  gnt, res_valid, res_data, busy
  );

  modport slave (
    input  req, lock, op_a, op_b,
    output gnt, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter with burst lock in front of one signed multiply-dequantize
// pipeline. Each result goes back to its issuer PIPE_STAGES cycles after the issue.
//
// state     | meaning
// ST_OPEN   | no owner; round-robin search starts at r_ptr
// ST_LOCKED | r_own holds the unit; only r_own can be granted
module mac_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int QUANT_BITS  = 10,
  parameter int PIPE_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  mac_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] ROUND_BIAS =
    (PW'(1) << QUANT_BITS) - PW'(1);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_own, w_own_nxt;

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_issue;
  logic [IDX_W-1:0]   w_win;
  int                 w_j;

  logic signed [PW-1:0]   w_a_ext, w_b_ext, w_prod, w_adj, w_quot;
  logic [DATA_WIDTH-1:0]  w_res;

  logic [PIPE_STAGES-1:0] r_pipe_v;
  logic [IDX_W-1:0]       r_pipe_idx  [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  r_pipe_data [PIPE_STAGES];

  // Grant selection; gnt is held at zero during reset so nothing issues.
  always_comb begin
    w_gnt   = '0;
    w_issue = 1'b0;
    w_win   = '0;
    w_j     = 0;
    if (!reset) begin
      if (r_state == ST_LOCKED) begin
        if (bus.req[r_own]) begin
          w_issue = 1'b1;
          w_win   = r_own;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          w_j = int'(r_ptr) + k;
          if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
          if (!w_issue && bus.req[w_j]) begin
            w_issue = 1'b1;
            w_win   = IDX_W'(w_j);
          end
        end
      end
      if (w_issue) w_gnt[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_ptr_nxt   = r_ptr;
    if (w_issue) begin
      w_ptr_nxt = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      if (bus.lock[w_win]) begin
        w_state_nxt = ST_LOCKED;
        w_own_nxt   = w_win;
      end else begin
        w_state_nxt = ST_OPEN;
      end
    end else if (r_state == ST_LOCKED && !bus.lock[r_own]) begin
      w_state_nxt = ST_OPEN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_OPEN;
      r_ptr   <= '0;
      r_own   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_own   <= w_own_nxt;
    end
  end

  // Negative products get a bias before the shift so the quotient truncates toward zero.
  always_comb begin
    w_a_ext = {{DATA_WIDTH{bus.op_a[w_win][DATA_WIDTH-1]}}, bus.op_a[w_win]};
    w_b_ext = {{DATA_WIDTH{bus.op_b[w_win][DATA_WIDTH-1]}}, bus.op_b[w_win]};
    w_prod  = w_a_ext * w_b_ext;
    w_adj   = w_prod[PW-1] ? (w_prod + ROUND_BIAS) : w_prod;
    w_quot  = w_adj >>> QUANT_BITS;
    w_res   = w_quot[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipe_v <= '0;
    end else begin
      r_pipe_v[0] <= w_issue;
      for (int s = 1; s < PIPE_STAGES; s++) r_pipe_v[s] <= r_pipe_v[s-1];
    end
  end

  always_ff @(posedge clock) begin
    r_pipe_idx[0]  <= w_win;
    r_pipe_data[0] <= w_res;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      r_pipe_idx[s]  <= r_pipe_idx[s-1];
      r_pipe_data[s] <= r_pipe_data[s-1];
    end
  end

  always_comb begin
    bus.gnt       = w_gnt;
    bus.res_valid = '0;
    bus.res_data  = '0;
    bus.busy      = !reset && (|r_pipe_v);
    if (!reset && r_pipe_v[PIPE_STAGES-1]) begin
      bus.res_valid[r_pipe_idx[PIPE_STAGES-1]] = 1'b1;
      bus.res_data = r_pipe_data[PIPE_STAGES-1];
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: a per-cycle vector table covering round-robin,
// dequantize rounding, burst lock and abandon, plus a hand-written mid-operation reset.
module tb_mac_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mac_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  mac_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .QUANT_BITS(10), .PIPE_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] lock;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [NR-1:0] gnt;
    logic [NR-1:0] rv;
    logic [DW-1:0] rd;
    logic          busy;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(logic [NR-1:0] req, logic [NR-1:0] lock,
                              logic [DW-1:0] a, logic [DW-1:0] b,
                              logic [NR-1:0] gnt, logic [NR-1:0] rv,
                              logic [DW-1:0] rd, logic busy);
    vec_t v;
    v.req = req; v.lock = lock; v.a = a; v.b = b;
    v.gnt = gnt; v.rv = rv; v.rd = rd; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=0x%08h expected=0x%08h", name, idx, act, exp);
    end
  endtask

  // Operands for the intended winner; distinct junk on every other requester
  // so a wrong operand select shows up in the result.
  task automatic set_ops(input logic [NR-1:0] sel, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    for (int i = 0; i < NR; i++) begin
      if (sel[i]) begin
        bus.op_a[i] = a;
        bus.op_b[i] = b;
      end else begin
        bus.op_a[i] = 32'h0010_0000 + DW'(i);
        bus.op_b[i] = 32'h0001_0000;
      end
    end
  endtask

  task automatic check_outs(input int idx, input logic [NR-1:0] gnt,
                            input logic [NR-1:0] rv, input logic [DW-1:0] rd,
                            input logic busy);
    check("gnt",       idx, DW'(bus.gnt),       DW'(gnt));
    check("res_valid", idx, DW'(bus.res_valid), DW'(rv));
    check("res_data",  idx, bus.res_data,       rd);
    check("busy",      idx, DW'(bus.busy),      DW'(busy));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 req      lock     a             b             gnt      rv       rd            busy
    vecs[0]  = mk(4'b1111, 4'b0000, 32'd178,      32'd1000,     4'b0001, 4'b0000, 32'd0,        1'b0);
    vecs[1]  = mk(4'b1111, 4'b0000, 32'hFFFFFD66, 32'd1000,     4'b0010, 4'b0000, 32'd0,        1'b1);
    vecs[2]  = mk(4'b1111, 4'b0000, 32'd3,        32'hFFFFFFFF, 4'b0100, 4'b0001, 32'd173,      1'b1);
    vecs[3]  = mk(4'b1111, 4'b0000, 32'hFFFFF800, 32'd3,        4'b1000, 4'b0010, 32'hFFFFFD76, 1'b1);
    vecs[4]  = mk(4'b1111, 4'b0000, 32'd1024,     32'hFFFFFC00, 4'b0001, 4'b0100, 32'd0,        1'b1);
    vecs[5]  = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b1000, 32'hFFFFFFFA, 1'b1);
    vecs[6]  = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0001, 32'hFFFFFC00, 1'b1);
    vecs[7]  = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0000, 32'd0,        1'b0);
    vecs[8]  = mk(4'b0101, 4'b0100, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0100, 4'b0000, 32'd0,        1'b0);
    vecs[9]  = mk(4'b0101, 4'b0100, 32'd5,        32'd1024,     4'b0100, 4'b0000, 32'd0,        1'b1);
    vecs[10] = mk(4'b0001, 4'b0100, 32'd0,        32'd0,        4'b0000, 4'b0100, 32'hFFC00000, 1'b1);
    vecs[11] = mk(4'b0101, 4'b0100, 32'hFFFFFFFB, 32'd1024,     4'b0100, 4'b0100, 32'd5,        1'b1);
    vecs[12] = mk(4'b0101, 4'b0000, 32'd7,        32'd2048,     4'b0100, 4'b0000, 32'd0,        1'b1);
    vecs[13] = mk(4'b0101, 4'b0000, 32'd1,        32'd1,        4'b0001, 4'b0100, 32'hFFFFFFFB, 1'b1);
    vecs[14] = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0100, 32'd14,       1'b1);
    vecs[15] = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0001, 32'd0,        1'b1);
    vecs[16] = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0000, 32'd0,        1'b0);
    vecs[17] = mk(4'b1000, 4'b1000, 32'hFFFFFFFF, 32'd1025,     4'b1000, 4'b0000, 32'd0,        1'b0);
    vecs[18] = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0000, 32'd0,        1'b1);
    vecs[19] = mk(4'b0011, 4'b0000, 32'd2,        32'd512,      4'b0001, 4'b1000, 32'hFFFFFFFF, 1'b1);
    vecs[20] = mk(4'b0010, 4'b0000, 32'd2,        32'd512,      4'b0010, 4'b0000, 32'd0,        1'b1);
    vecs[21] = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0001, 32'd1,        1'b1);
    vecs[22] = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0010, 32'd1,        1'b1);
    vecs[23] = mk(4'b0000, 4'b0000, 32'd0,        32'd0,        4'b0000, 4'b0000, 32'd0,        1'b0);

    bus.req  = '0;
    bus.lock = '0;
    set_ops('0, '0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.req = 4'b1111;
    @(negedge clock);
    check_outs(-1, 4'b0000, 4'b0000, 32'd0, 1'b0);

    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < NV; k++) begin
      bus.req  = vecs[k].req;
      bus.lock = vecs[k].lock;
      set_ops(vecs[k].gnt, vecs[k].a, vecs[k].b);
      @(negedge clock);
      check_outs(k, vecs[k].gnt, vecs[k].rv, vecs[k].rd, vecs[k].busy);
      next_cycle();
    end

    // Mid-operation reset: requester 1 issues, reset follows next cycle.
    bus.req  = 4'b0010;
    bus.lock = 4'b0000;
    set_ops(4'b0010, 32'd178, 32'd1000);
    @(negedge clock);
    check_outs(100, 4'b0010, 4'b0000, 32'd0, 1'b0);
    next_cycle();

    reset   = 1'b1;
    bus.req = 4'b1111;
    @(negedge clock);
    check_outs(101, 4'b0000, 4'b0000, 32'd0, 1'b0);
    next_cycle();

    reset   = 1'b0;
    bus.req = 4'b0110;
    set_ops(4'b0010, 32'd3, 32'd1024);
    @(negedge clock);
    check_outs(102, 4'b0010, 4'b0000, 32'd0, 1'b0);
    next_cycle();

    bus.req = 4'b0000;
    @(negedge clock);
    check_outs(103, 4'b0000, 4'b0000, 32'd0, 1'b1);
    next_cycle();

    @(negedge clock);
    check_outs(104, 4'b0000, 4'b0010, 32'd3, 1'b1);
    next_cycle();

    @(negedge clock);
    check_outs(105, 4'b0000, 4'b0000, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Shares one signed multiply-dequantize unit among `NUM_REQ` filter engines, such as the IIR feed-forward and feedback paths and the FIR channel filters. Each engine loses its private multipliers and uses this block instead.

The block arbitrates round-robin between requesters. A requester can lock the unit for a burst of consecutive multiplies, for example one full dot product. The block returns each dequantized product to its issuer after a fixed pipeline latency. It sits between the filter state machines and the single hardware multiplier in the FM radio datapath.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `DATA_WIDTH`, default 32: operand and result width.
- `QUANT_BITS`, default 10: dequantize divisor is 2^`QUANT_BITS` (1024).
- `PIPE_STAGES`, default 2: issue-to-result latency in cycles, at least 1.

Ports (clock is single; reset is synchronous, active-high):
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous active-high reset.
- `req`  in  `NUM_REQ`  per-requester multiply request.
- `lock`  in  `NUM_REQ`  per-requester burst hold; sampled with each issue.
- `op_a`  in  `NUM_REQ` x `DATA_WIDTH`  signed operand A (coefficient).
- `op_b`  in  `NUM_REQ` x `DATA_WIDTH`  signed operand B (sample).
- `gnt`  out  `NUM_REQ`  one-hot or zero; combinational from state and `req`.
- `res_valid`  out  `NUM_REQ`  one-hot or zero; result strobe to the issuer.
- `res_data`  out  `DATA_WIDTH`  dequantized product.
- `busy`  out  1  high while any pipeline stage holds a valid operation.

## Operation
- An issue occurs in a cycle where `req[i]` and `gnt[i]` are both high. At most one issue happens per cycle.
- Registered state:
  - rotate pointer `ptr`;
  - lock owner `own` plus `own_v`;
  - pipeline of `PIPE_STAGES` entries, each holding a valid bit, a requester index and data.
- Grant rules:
  - If `own_v`: `gnt[own] = req[own]`; all other grants are 0. An owner with `req` low causes a bubble; others still wait.
  - If not `own_v`: grant the first `i` with `req[i]`=1, searching `ptr`, `ptr+1`, … modulo `NUM_REQ`. Grant nothing if no `req` is asserted.
- On an issue by requester `w`:
  - `ptr` ← (`w`+1) mod `NUM_REQ`.
  - If `lock[w]`=1, set `own`←`w` and `own_v`←1.
  - If `lock[w]`=0, set `own_v`←0. This issue is the last of the burst, and arbitration reopens next cycle.
- Abandon: if `own_v` and `lock[own]`=0 with no issue that cycle, clear `own_v` at the clock edge.
- Arithmetic:
  - Form the full 2·`DATA_WIDTH` signed product of `op_a` × `op_b`.
  - Divide by 2^`QUANT_BITS`, truncating toward zero (C integer-division semantics, not an arithmetic shift).
  - Take the low `DATA_WIDTH` bits and wrap on overflow; no saturation.
- Result return:
  - Stage `PIPE_STAGES` drives `res_valid[idx]` and `res_data`.
  - `res_data` is 0 when no stage-out entry is valid.
- Reset:
  - `ptr`=0, `own_v`=0, all pipeline valid bits cleared.
  - `gnt` is forced to 0 while `reset` is high.
  - `res_valid`=0, `res_data`=0, `busy`=0.
  - In-flight operations are discarded; no result is delivered after reset.

## Timing
- Issue in cycle t produces `res_valid[w]`=1 in cycle t+`PIPE_STAGES` for exactly one cycle.
- Throughput is one issue per cycle with no dead cycle between bursts or requesters.
- Lock release by an issue with `lock`=0 in cycle t: a different requester can issue in cycle t+1.
- `gnt` follows `req` within the same cycle (combinational). Requesters hold `op_a`/`op_b` stable while `req` is high.
- `busy` goes high the cycle after the first issue. It falls the cycle after the last result strobe.
- Simultaneous issue and result delivery is legal every cycle.

## Test plan
- Single op, NUM_REQ=4, PIPE_STAGES=2: requester 1 issues `op_a`=0x000000B2, `op_b`=1000 at cycle 5 -> `res_valid[1]`=1 at cycle 7, `res_data`=173 (0x000000AD).
- Rounding toward zero: `op_a`=0xFFFFFD66 (-666), `op_b`=1000 -> `res_data`=-650 (0xFFFFFD76), not -651.
- Round-robin: `req`=4'b1111 held with `lock`=0 from reset -> grant order 0,1,2,3,0,1,…, one issue per cycle, results returned in the same order two cycles later.
- Burst lock: requester 2 issues 4 ops, `lock`=1 on the first 3 and 0 on the 4th, while `req[0]` stays high -> requester 0 is not granted until the cycle after the 4th issue. A `req[2]` bubble mid-burst keeps `gnt[0]`=0.
- Abandon: requester 3 locks, then drops both `req` and `lock` -> `own_v` clears, and the next eligible requester is granted the following cycle.
- Reset mid-operation: assert `reset` one cycle after an issue -> no `res_valid` ever strobes for it, `busy`=0, `ptr`=0, and the first post-reset grant goes to the lowest requesting index.
